mac_sequencer: RTL and testbench
================================

// Module: mac_sequencer
// PURPOSE
//  Upstream controller for the MAC unit: accepts a valid/ready stream of (x, w) pairs forming one dot product.
//  Registers each pair onto the MAC operand inputs and drives mac_acc_loopback / mac_acc_update.
//  After the vector's last pair, reads the MAC accumulator, applies the activation and presents one result
//  with a valid/ready handshake. One vector is in flight at a time.
// PARAMETERS
//  MAX_LEN   256  max terms per vector; the MAX_LEN-th accepted pair ends the vector even without in_last
//  ACT_RELU  0    0 = identity, 1 = ReLU (negative accumulator -> 0)
// PORTS
//  clk              in   1       clock, all state on posedge
//  rst              in   1       synchronous, active-high reset
//  in_valid         in   1       (x, w) pair valid
//  in_ready         out  1       sequencer accepts pair this cycle
//  in_x             in   Q_SIZE  activation operand, fixed Q_INT.Q_FRAC
//  in_w             in   Q_SIZE  weight operand, same format
//  in_last          in   1       pair is the final term of the vector
//  mac_x            out  Q_SIZE  to MAC x (registered)
//  mac_w            out  Q_SIZE  to MAC w (registered)
//  mac_acc_loopback out  1       to MAC: 0 on first term, 1 on later terms
//  mac_acc_update   out  1       to MAC: acc write enable
//  mac_acc          in   Q_SIZE  from MAC registered acc output
//  out_valid        out  1       result valid
//  out_ready        in   1       consumer takes result
//  out_data         out  Q_SIZE  activated result
//  out_count        out  $clog2(MAX_LEN+1)  number of terms in the result's vector
//  out_trunc        out  1       vector ended by MAX_LEN, not in_last
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (in_ready 0 during the reset cycle, 1 the cycle after); MAC acc is not written.
//  - Accept = in_valid & in_ready at a posedge. in_ready = (state == IDLE || state == ACCUM).
//  - Operand stage: on accept, mac_x <= in_x, mac_w <= in_w, mac_acc_update <= 1, mac_acc_loopback <= (term index != 0).
//    No accept -> mac_acc_update <= 0; mac_x/mac_w hold. The MAC acc is written one edge after the accept edge.
//  - FSM:
//    IDLE  : accept -> ACCUM (cnt <= 1); if last/limit -> WAIT.
//    ACCUM : accept -> cnt++; if in_last or cnt+1 == MAX_LEN -> WAIT. in_valid gaps allowed; state holds.
//    WAIT  : in_ready 0; the final update is in flight. Next edge -> CAPT.
//    CAPT  : mac_acc is final; out_data <= act(mac_acc), out_count <= cnt, out_trunc <= limit_hit, out_valid <= 1 -> OUT.
//    OUT   : out_valid held; out_data/count/trunc stable. out_ready=1 -> out_valid <= 0, cnt <= 0, -> IDLE.
//  - Latency: last-pair accept edge t -> acc written at edge t+1 -> out_valid high after edge t+2.
//  - Length-1 vector: loopback 0, so the result is the single saturated product.
//  - Arithmetic: no widening here; saturation is the MAC's job. ReLU: out = mac_acc[Q_INT-1] ? 0 : mac_acc.
//  - in_last together with limit: out_trunc = 0 (in_last wins).
//  - out_ready while not out_valid: ignored. in_ready is 0 in WAIT/CAPT/OUT, even if out_ready = 1.
//  - Reset mid-vector: partial sum discarded; the next vector's first term uses loopback 0, so stale acc is ignored.
// STRUCTURE
//  - definitions pkg: add typedef fixed_t (logic signed [Q_INT-1:-Q_FRAC]) and enum seq_state_t {IDLE, ACCUM, WAIT, CAPT, OUT}.
//    Reuse Q_INT/Q_FRAC/Q_SIZE from the pkg.
//  - Single flat module: FSM + term counter + operand register + result register. No sub-module.
//    The bench and top level connect it to MacUnit.
// TESTING (bench instantiates mac_sequencer + MacUnit)
//  1 x={1.0,2.0,-0.5}, w={0.5,0.5,2.0}, last on 3rd, ACT_RELU=0 -> out_data=0.5, out_count=3, out_trunc=0;
//    out_valid 2 cycles after 3rd accept.
//  2 Single pair x=-1.5, w=2.0, last; ACT_RELU=0 -> -3.0; ACT_RELU=1 -> 0.0; loopback=0 on that term.
//  3 3-term vector with in_valid low 4 cycles between terms -> same result as case 1; mac_acc_update=0 in gap cycles.
//  4 out_ready low 5 cycles after out_valid -> out_valid/out_data stable; in_ready=0 throughout;
//    next vector's first accept occurs 1 cycle after handshake.
//  5 MAX_LEN=4, feed 6 pairs of 0.25*1.0, no in_last -> result 1.0, out_count=4, out_trunc=1; pairs 5-6 start a new vector.
//  6 rst after 2 accepted terms -> all outputs 0, IDLE; new vector {1.0*1.0} -> out_data=1.0 (no stale sum).

Source files
------------

// File: rtl/mac_sequencer_pkg.sv
// Shared fixed-point format and sequencer state encoding for the MAC front end.
package mac_sequencer_pkg;

    localparam int Q_INT  = 8;
    localparam int Q_FRAC = 8;
    localparam int Q_SIZE = Q_INT + Q_FRAC;

    typedef logic signed [Q_INT-1:-Q_FRAC] fixed_t;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        WAIT,
        CAPT,
        OUT
    } seq_state_t;

endpackage

// File: rtl/mac_sequencer.sv
// Streams (x, w) pairs into an external MAC, then reads back the final
// accumulator, applies the activation and hands one result downstream.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int MAX_LEN  = 256,
    parameter bit ACT_RELU = 1'b0,
    localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  fixed_t           in_x,
    input  fixed_t           in_w,
    input  logic             in_last,
    output fixed_t           mac_x,
    output fixed_t           mac_w,
    output logic             mac_acc_loopback,
    output logic             mac_acc_update,
    input  fixed_t           mac_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output fixed_t           out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc
);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             limit_hit;
    logic             accept;
    logic             at_limit;
    logic             vec_end;

    function automatic fixed_t activate(input fixed_t a);
        if (ACT_RELU && a[Q_INT-1]) begin
            return '0;
        end
        return a;
    endfunction

    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt + CNT_W'(1);
    assign at_limit = (cnt_inc == CNT_W'(MAX_LEN));
    assign vec_end  = in_last || at_limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            limit_hit        <= 1'b0;
            in_ready         <= 1'b0;
            mac_x            <= '0;
            mac_w            <= '0;
            mac_acc_loopback <= 1'b0;
            mac_acc_update   <= 1'b0;
            out_valid        <= 1'b0;
            out_data         <= '0;
            out_count        <= '0;
            out_trunc        <= 1'b0;
        end else begin
            // Operand stage: the MAC sees the pair one edge after acceptance.
            mac_acc_update <= accept;
            if (accept) begin
                mac_x            <= in_x;
                mac_w            <= in_w;
                mac_acc_loopback <= (cnt != '0);
            end

            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        cnt       <= cnt_inc;
                        limit_hit <= at_limit && !in_last;
                        if (vec_end) begin
                            state    <= WAIT;
                            in_ready <= 1'b0;
                        end else begin
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                // Final update is still being written into the MAC accumulator.
                WAIT: begin
                    state    <= CAPT;
                    in_ready <= 1'b0;
                end
                CAPT: begin
                    out_data  <= activate(mac_acc);
                    out_count <= cnt;
                    out_trunc <= limit_hit;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench: two sequencers (identity and ReLU) sharing one stimulus stream, each
// driving its own behavioural MAC; results are checked through a scoreboard.
module tb_mac_sequencer;
    import mac_sequencer_pkg::*;

    localparam int ML = 4;
    localparam int CW = $clog2(ML + 1);

    logic   clk = 1'b0;
    always #5 clk = ~clk;

    logic   rst, in_valid, in_last, out_ready;
    fixed_t in_x, in_w;

    logic          in_ready_a, upd_a, lb_a, out_valid_a, out_trunc_a;
    fixed_t        mac_x_a, mac_w_a, out_data_a;
    fixed_t        acc_a = fixed_t'(1000);
    logic [CW-1:0] out_count_a;

    logic          in_ready_b, upd_b, lb_b, out_valid_b, out_trunc_b;
    fixed_t        mac_x_b, mac_w_b, out_data_b;
    fixed_t        acc_b = fixed_t'(-700);
    logic [CW-1:0] out_count_b;

    mac_sequencer #(.MAX_LEN(ML), .ACT_RELU(1'b0)) dut_id (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_x(in_x), .in_w(in_w), .in_last(in_last),
        .mac_x(mac_x_a), .mac_w(mac_w_a), .mac_acc_loopback(lb_a),
        .mac_acc_update(upd_a), .mac_acc(acc_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_count(out_count_a), .out_trunc(out_trunc_a)
    );

    mac_sequencer #(.MAX_LEN(ML), .ACT_RELU(1'b1)) dut_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_x(in_x), .in_w(in_w), .in_last(in_last),
        .mac_x(mac_x_b), .mac_w(mac_w_b), .mac_acc_loopback(lb_b),
        .mac_acc_update(upd_b), .mac_acc(acc_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_count(out_count_b), .out_trunc(out_trunc_b)
    );

    // Behavioural MAC: saturating Q8.8 multiply-accumulate, no reset.
    function automatic fixed_t mac_step(fixed_t acc, fixed_t x, fixed_t w, logic lb);
        int p, s;
        p = (int'(x) * int'(w)) >>> Q_FRAC;
        s = lb ? int'(acc) + p : p;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return fixed_t'(s);
    endfunction

    always @(posedge clk) begin
        if (upd_a) acc_a <= mac_step(acc_a, mac_x_a, mac_w_a, lb_a);
        if (upd_b) acc_b <= mac_step(acc_b, mac_x_b, mac_w_b, lb_b);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int d_id;
        int d_relu;
        int cnt;
        int trunc;
    } exp_t;
    exp_t sb[$];

    task automatic push(input int d, input int cnt, input int trunc);
        exp_t e;
        e.d_id   = d;
        e.d_relu = (d < 0) ? 0 : d;
        e.cnt    = cnt;
        e.trunc  = trunc;
        sb.push_back(e);
    endtask

    // Monitor state
    int     terms     = 0;
    int     since_end = 1000;
    logic   exp_upd   = 1'b0;
    logic   exp_lb    = 1'b0;
    int     exp_x     = 0;
    logic   prev_valid = 1'b0;
    logic   prev_hs    = 1'b0;
    int     prev_data  = 0;

    always @(negedge clk) begin
        logic acc_now, ends;
        exp_t e;
        if (rst) begin
            terms      = 0;
            since_end  = 1000;
            exp_upd    = 1'b0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            check("mac_acc_update", upd_a, exp_upd);
            if (exp_upd) begin
                check("mac_acc_loopback", lb_a, exp_lb);
                check("mac_x", int'(mac_x_a), exp_x);
            end
            if (out_valid_a && !prev_valid) check("result_latency", since_end, 2);
            if (out_valid_a && prev_valid) check("out_data_hold", int'(out_data_a), prev_data);
            if (out_valid_a) check("in_ready_while_out", in_ready_a, 0);
            if (prev_hs) check("in_ready_after_handshake", in_ready_a, 1);
            check("relu_valid_align", out_valid_b, out_valid_a);

            if (out_valid_a && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", int'(out_data_a), e.d_id);
                    check("out_data_relu", int'(out_data_b), e.d_relu);
                    check("out_count", int'(out_count_a), e.cnt);
                    check("out_trunc", out_trunc_a, e.trunc);
                end
            end

            acc_now = in_valid && in_ready_a;
            ends    = 1'b0;
            exp_upd = acc_now;
            if (acc_now) begin
                exp_lb = (terms != 0);
                exp_x  = int'(in_x);
                ends   = in_last || (terms + 1 == ML);
                terms  = ends ? 0 : terms + 1;
            end
            if (acc_now && ends) since_end = 0;
            else if (since_end < 1000) since_end++;

            prev_valid = out_valid_a;
            prev_data  = int'(out_data_a);
            prev_hs    = out_valid_a && out_ready;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int x, input int w, input logic last);
        int n;
        in_x     = fixed_t'(x);
        in_w     = fixed_t'(w);
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready_a && n < 50) begin
            tick(1);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 0, 1);
        tick(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_data", int'(out_data_a), 0);
        check("rst_out_count", int'(out_count_a), 0);
        check("rst_out_trunc", out_trunc_a, 0);
        check("rst_mac_x", int'(mac_x_a), 0);
        check("rst_mac_w", int'(mac_w_a), 0);
        check("rst_mac_update", upd_a, 0);
        check("rst_mac_loopback", lb_a, 0);
        check("rst_in_ready", in_ready_a, 0);
        check("rst_in_ready_relu", in_ready_b, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_x = '0; in_w = '0;
        tick(2);
        check_reset_outputs();
        rst = 1'b0;
        tick(1);
        check("in_ready_after_rst", in_ready_a, 1);

        // 1.0*0.5 + 2.0*0.5 + (-0.5)*2.0 = 0.5
        push(128, 3, 0);
        send(256, 128, 0); send(512, 128, 0); send(-128, 512, 1);

        // Single pair: -1.5*2.0 = -3.0, ReLU -> 0
        push(-768, 1, 0);
        send(-384, 512, 1);

        // Same vector as the first with 4-cycle gaps
        push(128, 3, 0);
        send(256, 128, 0); tick(4);
        send(512, 128, 0); tick(4);
        send(-128, 512, 1);
        drain();

        // Consumer stalls 5 cycles; next vector waits for the handshake
        out_ready = 1'b0;
        push(256, 1, 0);
        send(256, 256, 1);
        n = 0;
        while (!out_valid_a && n < 20) begin
            tick(1);
            n++;
        end
        check("out_valid_seen", out_valid_a, 1);
        tick(5);
        out_ready = 1'b1;
        push(64, 1, 0);
        send(64, 256, 1);

        // Six 0.25*1.0 pairs with no last: first four truncate, rest start anew
        push(256, 4, 1);
        push(192, 3, 0);
        repeat (6) send(64, 256, 0);
        send(64, 256, 1);

        // in_last coinciding with the length limit is not a truncation
        push(256, 4, 0);
        repeat (3) send(128, 128, 0);
        send(128, 128, 1);
        drain();

        // Reset mid-vector discards the partial sum
        send(256, 256, 0); send(256, 256, 0);
        rst = 1'b1;
        tick(1);
        check_reset_outputs();
        rst = 1'b0;
        push(256, 1, 0);
        send(256, 256, 1);
        drain();
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
